// File: rtl/twisted_ring_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : twisted_ring_counter_if
// Description : Control and status bundle for twisted_ring_counter.
//               master drives the controls and observes the status;
//               slave is the counter side.
// Signals     : en        shift enable (0 = hold)
//               mode[1:0] 00 SHIFT, 01 RING, 10 JOHNSON, 11 JOHNSON_IN
//               dir       0 = shift toward MSB, 1 = shift toward LSB
//               load      synchronous parallel load, overrides en
//               load_val  value captured on load
//               ser_in    serial input for SHIFT and JOHNSON_IN
//               q         register contents
//               phase     steps since last reset/load/mode change
//               wrap      one-cycle pulse after a completed period
//               illegal   registered "q is not a Johnson pattern" flag
// Revision    : 1.0  initial release
// ============================================================================
interface twisted_ring_counter_if #(
    parameter int WIDTH = 5
);
    localparam int PW = $clog2(2 * WIDTH);

    logic             en;
    logic [1:0]       mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    phase;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, mode, dir, load, load_val, ser_in,
        input  q, phase, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val, ser_in,
        output q, phase, wrap, illegal
    );
endinterface
`default_nettype wire

// File: rtl/twisted_ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : twisted_ring_counter
// Description : Parametrised shift / ring / Johnson counter with selectable
//               direction, synchronous parallel load, phase tracker, wrap
//               pulse and illegal Johnson pattern detection.
// Ports       : clk      clock, all state changes on the rising edge
//               clear_n  asynchronous active-low reset
//               bus      twisted_ring_counter_if.slave (controls + status)
// Parameters  : WIDTH    register length, 2..32
// Options     : TRC_AUTOCORRECT_EN  when defined, an enabled edge in a
//               Johnson mode that sees an illegal pattern clears q and phase
//               instead of shifting.
// Revision    : 1.0  initial release
// ============================================================================
module twisted_ring_counter #(
    parameter int WIDTH = 5
) (
    input logic                   clk,
    input logic                   clear_n,
    twisted_ring_counter_if.slave bus
);

    localparam int              PW         = $clog2(2 * WIDTH);
    localparam int              DW         = WIDTH - 1;
    localparam logic [1:0]      MODE_SHIFT = 2'b00;
    localparam logic [1:0]      MODE_RING  = 2'b01;
    localparam logic [1:0]      MODE_JOHN  = 2'b10;
    localparam logic [1:0]      MODE_JIN   = 2'b11;
    localparam logic [PW-1:0]   LAST_SHORT = PW'(WIDTH - 1);
    localparam logic [PW-1:0]   LAST_LONG  = PW'(2 * WIDTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_q,       q_d;
    logic [PW-1:0]    phase_q,   phase_d;
    logic             wrap_q,    wrap_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       mode_q,    mode_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [DW-1:0]    w_diff;
    logic             w_legal;
    logic             w_exit;
    logic             w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic [PW-1:0]    w_last;
    logic             w_mode_change;
    logic             w_correct;

    // A legal Johnson pattern (0*1* or 1*0*) has at most one boundary
    // between neighbouring bits that differ; the one-hot-or-zero test on
    // the neighbour-difference vector checks exactly that.
    assign w_diff  = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
    assign w_legal = ((w_diff & (w_diff - DW'(1))) == '0);

    assign w_exit = bus.dir ? q_q[0] : q_q[WIDTH-1];

    always_comb begin
        w_fill = bus.ser_in;
        case (bus.mode)
            MODE_SHIFT: w_fill = bus.ser_in;
            MODE_RING:  w_fill = w_exit;
            MODE_JOHN:  w_fill = ~w_exit;
            MODE_JIN:   w_fill = bus.ser_in | ~w_exit;
            default:    w_fill = bus.ser_in;
        endcase
    end

    assign w_shifted = bus.dir ? {w_fill, q_q[WIDTH-1:1]}
                               : {q_q[WIDTH-2:0], w_fill};

    // Johnson modes cycle through 2*WIDTH states, shift/ring through WIDTH.
    assign w_last        = bus.mode[1] ? LAST_LONG : LAST_SHORT;
    assign w_mode_change = (bus.mode != mode_q);

`ifdef TRC_AUTOCORRECT_EN
    assign w_correct = bus.en & bus.mode[1] & ~w_legal;
`else
    assign w_correct = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state: load > autocorrect > shift > hold
    // ------------------------------------------------------------------
    always_comb begin
        q_d     = q_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            q_d     = bus.load_val;
            phase_d = '0;
        end else if (w_correct) begin
            q_d     = '0;
            phase_d = '0;
        end else if (bus.en) begin
            // A mode change restarts the phase but the shift itself already
            // follows the new mode.
            q_d = w_shifted;
            if (w_mode_change) begin
                phase_d = '0;
            end else if (phase_q == w_last) begin
                phase_d = '0;
                wrap_d  = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end else if (w_mode_change) begin
            phase_d = '0;
        end
    end

    // Flag reflects the pattern present before this edge; SHIFT/RING never
    // flag because mode[1] is clear.
    assign illegal_d = bus.mode[1] & ~w_legal;
    assign mode_d    = bus.mode;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q       <= '0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            mode_q    <= '0;
        end else begin
            q_q       <= q_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            mode_q    <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.q       = q_q;
    assign bus.phase   = phase_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal_q;

endmodule
`default_nettype wire
